// File: rtl/uart_burst_tx_if.sv
// Handshake and serial-line bundle for uart_burst_tx.
// The master side drives the burst request; the slave side is the transmitter.
interface uart_burst_tx_if #(
  parameter int LEN_WIDTH = 8,
  parameter int NUM_BYTES = 134
);
  logic                     start;
  logic                     repeat_en;
  logic [LEN_WIDTH-1:0]     length;
  logic [NUM_BYTES*8-1:0]   payload_in;
  logic                     tx_out;
  logic                     busy;
  logic [LEN_WIDTH-1:0]     byte_index;
  logic                     done;

  modport master (
    output start, repeat_en, length, payload_in,
    input  tx_out, busy, byte_index, done
  );

  modport slave (
    input  start, repeat_en, length, payload_in,
    output tx_out, busy, byte_index, done
  );
endinterface

// File: rtl/uart_burst_tx.sv
// Multi-byte UART burst transmitter: shadows a wide payload, then sends it
// byte 0 first, LSB first, with optional parity, 1 or 2 stop bits and an
// optional auto-repeat with an idle-high gap between bursts.
module uart_burst_tx #(
  parameter int TICKS_PER_BIT = 65,
  parameter int TICKS_WIDTH   = 7,
  parameter int NUM_BYTES     = 134,
  parameter int LEN_WIDTH     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int GAP_TICKS     = 15
) (
  input  logic            clk_in,
  input  logic            reset,
  uart_burst_tx_if.slave  bus
);

  localparam int PAY_W = NUM_BYTES * 8;
  localparam logic [TICKS_WIDTH-1:0] TICK_LAST = TICKS_WIDTH'(TICKS_PER_BIT - 1);
  localparam logic [TICKS_WIDTH-1:0] GAP_LAST  = TICKS_WIDTH'(GAP_TICKS - 1);
  localparam logic [TICKS_WIDTH-1:0] TICK_ONE  = TICKS_WIDTH'(1);
  localparam logic [2:0]             STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LEN_WIDTH-1:0]   MAX_LEN   = LEN_WIDTH'(NUM_BYTES);
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
  localparam logic                   ODD_PAR   = (PARITY_MODE == 2);
  localparam logic                   HAS_GAP   = (GAP_TICKS > 0);
  localparam logic                   HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t                 r_state, w_nextState;
  logic [TICKS_WIDTH-1:0] r_tickCnt, w_tickNext;
  logic [2:0]             r_bitCnt, w_bitNext;
  logic [LEN_WIDTH-1:0]   r_byteIdx, w_byteIdxNext;
  logic [LEN_WIDTH-1:0]   r_len, w_lenNext;
  logic [PAY_W-1:0]       r_payload, w_payloadNext;
  logic                   r_tx, w_txNext;
  logic                   r_busy, w_busyNext;
  logic                   r_done, w_doneNext;
  logic [7:0]             w_nextByte;

  logic [LEN_WIDTH-1:0]   w_lenClamped;
  logic                   w_zeroLen;
  logic                   w_tickLast;
  logic                   w_gapLast;
  logic                   w_lastByte;
  logic                   w_frameEnd;
  logic                   w_burstEnd;
  logic                   w_relatch;

  assign w_lenClamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
  assign w_zeroLen    = (w_lenClamped == '0);
  assign w_tickLast   = (r_tickCnt == TICK_LAST);
  assign w_gapLast    = (r_state == S_GAP) && (r_tickCnt == GAP_LAST);
  assign w_lastByte   = (r_byteIdx == r_len - LEN_ONE);
  assign w_frameEnd   = (r_state == S_STOP) && w_tickLast && (r_bitCnt == STOP_LAST);
  assign w_burstEnd   = w_frameEnd && w_lastByte;
  // A zero-gap repeat re-latches on the burst-end edge itself; a zero
  // re-latched length there merges its done pulse with the burst-end one.
  assign w_relatch    = ((r_state == S_IDLE) && bus.start)
                      || (w_burstEnd && bus.repeat_en && !HAS_GAP)
                      || w_gapLast;

  // State register plus all registered outputs and datapath shadows.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tickCnt <= '0;
      r_bitCnt  <= '0;
      r_byteIdx <= '0;
      r_len     <= '0;
      r_payload <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tickCnt <= w_tickNext;
      r_bitCnt  <= w_bitNext;
      r_byteIdx <= w_byteIdxNext;
      r_len     <= w_lenNext;
      r_payload <= w_payloadNext;
      r_tx      <= w_txNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  // Next-state decision: bit phases advance on the last tick of each bit.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (bus.start && !w_zeroLen) w_nextState = S_START;
      S_START:  if (w_tickLast) w_nextState = S_DATA;
      S_DATA:   if (w_tickLast && (r_bitCnt == 3'd7))
                  w_nextState = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_tickLast) w_nextState = S_STOP;
      S_STOP: begin
        if (w_frameEnd) begin
          if (!w_lastByte)         w_nextState = S_START;
          else if (!bus.repeat_en) w_nextState = S_IDLE;
          else if (HAS_GAP)        w_nextState = S_GAP;
          else                     w_nextState = w_zeroLen ? S_IDLE : S_START;
        end
      end
      S_GAP:    if (w_gapLast) w_nextState = w_zeroLen ? S_IDLE : S_START;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Next values of counters, shadows and line outputs, looked ahead so the
  // outputs themselves come straight from flops.
  always_comb begin
    w_lenNext     = r_len;
    w_payloadNext = r_payload;
    w_byteIdxNext = r_byteIdx;
    if (w_relatch) begin
      w_lenNext     = w_lenClamped;
      w_payloadNext = bus.payload_in;
      w_byteIdxNext = '0;
    end else if (w_frameEnd && !w_lastByte) begin
      w_payloadNext = r_payload >> 8;
      w_byteIdxNext = r_byteIdx + LEN_ONE;
    end else if (w_burstEnd) begin
      w_byteIdxNext = '0;
    end

    if ((w_nextState != r_state) || (w_nextState == S_IDLE))
      w_tickNext = '0;
    else if (w_tickLast && (r_state != S_GAP))
      w_tickNext = '0;
    else
      w_tickNext = r_tickCnt + TICK_ONE;

    if (w_nextState != r_state)
      w_bitNext = '0;
    else if (w_tickLast && ((r_state == S_DATA) || (r_state == S_STOP)))
      w_bitNext = r_bitCnt + 3'd1;
    else
      w_bitNext = r_bitCnt;

    w_nextByte = w_payloadNext[7:0];
    w_doneNext = w_burstEnd || (w_relatch && w_zeroLen);
    w_busyNext = (w_nextState != S_IDLE);

    case (w_nextState)
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_nextByte[w_bitNext];
      S_PARITY: w_txNext = (^w_nextByte) ^ ODD_PAR;
      default:  w_txNext = 1'b1;
    endcase
  end

  assign bus.tx_out     = r_tx;
  assign bus.busy       = r_busy;
  assign bus.byte_index = r_byteIdx;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Self-checking bench for uart_burst_tx: a queue-based waveform model is
// compared every cycle against the main instance, plus directed literal
// checks and a small UART receiver decoding the serial line.
module tb_uart_burst_tx;

  localparam int TPB = 4;
  localparam int NB  = 134;
  localparam int LW  = 8;
  localparam int GAP = 15;
  localparam int NBP = 4;
  localparam int FR  = TPB * 10;

  typedef struct packed {
    logic          tx;
    logic          busy;
    logic          done;
    logic [LW-1:0] idx;
    logic [1:0]    kind;
  } exp_t;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } smp_t;

  logic clk_in = 1'b0;
  logic reset;
  int   nChecks;
  int   nFails;

  exp_t expQ[$];
  exp_t expNow;
  smp_t logM[$];
  smp_t logE[$];
  smp_t logO[$];
  logic [7:0] rxBytes[$];
  int   donePos[$];

  always #5 clk_in = ~clk_in;

  uart_burst_tx_if #(.LEN_WIDTH(LW), .NUM_BYTES(NB))  busM ();
  uart_burst_tx_if #(.LEN_WIDTH(LW), .NUM_BYTES(NBP)) busE ();
  uart_burst_tx_if #(.LEN_WIDTH(LW), .NUM_BYTES(NBP)) busO ();

  uart_burst_tx #(.TICKS_PER_BIT(TPB), .TICKS_WIDTH(7), .NUM_BYTES(NB), .LEN_WIDTH(LW),
                  .PARITY_MODE(0), .STOP_BITS(1), .GAP_TICKS(GAP))
    dut (.clk_in(clk_in), .reset(reset), .bus(busM));

  uart_burst_tx #(.TICKS_PER_BIT(TPB), .TICKS_WIDTH(7), .NUM_BYTES(NBP), .LEN_WIDTH(LW),
                  .PARITY_MODE(1), .STOP_BITS(2), .GAP_TICKS(0))
    dutEven (.clk_in(clk_in), .reset(reset), .bus(busE));

  uart_burst_tx #(.TICKS_PER_BIT(TPB), .TICKS_WIDTH(7), .NUM_BYTES(NBP), .LEN_WIDTH(LW),
                  .PARITY_MODE(2), .STOP_BITS(2), .GAP_TICKS(0))
    dutOdd (.clk_in(clk_in), .reset(reset), .bus(busO));

  function automatic exp_t mk(input logic tx, input logic busy, input logic done,
                              input int idx, input int kind);
    exp_t e;
    e.tx   = tx;
    e.busy = busy;
    e.done = done;
    e.idx  = LW'(idx);
    e.kind = 2'(kind);
    return e;
  endfunction

  function automatic int clampLen(input logic [LW-1:0] l);
    return (int'(l) > NB) ? NB : int'(l);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Expected line waveform for one burst: each byte is a 10-bit frame
  // (start 0, 8 data bits LSB first, stop 1), every bit TPB cycles wide,
  // followed by a marker entry for the burst-end edge.
  task automatic pushBurst(input int len, input logic [NB*8-1:0] pay);
    logic [7:0] v;
    logic       bitVal;
    for (int b = 0; b < len; b++) begin
      v = pay[8*b +: 8];
      for (int p = 0; p < 10; p++) begin
        bitVal = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : v[p-1];
        for (int t = 0; t < TPB; t++) expQ.push_back(mk(bitVal, 1'b1, 1'b0, b, 0));
      end
    end
    expQ.push_back(mk(1'b1, 1'b0, 1'b1, 0, 1));
  endtask

  // Model and per-cycle comparison of the main instance.
  initial begin : modelCompare
    exp_t e;
    int   len;
    expNow = mk(1'b1, 1'b0, 1'b0, 0, 0);
    forever begin
      @(posedge clk_in);
      if (reset === 1'b1) begin
        expQ.delete();
        expNow = mk(1'b1, 1'b0, 1'b0, 0, 0);
      end else if (expQ.size() == 0) begin
        if (busM.start === 1'b1) begin
          len = clampLen(busM.length);
          if (len == 0) expNow = mk(1'b1, 1'b0, 1'b1, 0, 0);
          else begin
            pushBurst(len, busM.payload_in);
            expNow = expQ.pop_front();
          end
        end else begin
          expNow = mk(1'b1, 1'b0, 1'b0, 0, 0);
        end
      end else begin
        e = expQ.pop_front();
        if (e.kind == 2'd1) begin
          if (busM.repeat_en === 1'b1) begin
            expNow = mk(1'b1, 1'b1, 1'b1, 0, 0);
            for (int g = 0; g < GAP - 1; g++) expQ.push_back(mk(1'b1, 1'b1, 1'b0, 0, 0));
            expQ.push_back(mk(1'b1, 1'b1, 1'b0, 0, 2));
          end else begin
            expNow = mk(1'b1, 1'b0, 1'b1, 0, 0);
          end
        end else if (e.kind == 2'd2) begin
          len = clampLen(busM.length);
          if (len == 0) expNow = mk(1'b1, 1'b0, 1'b1, 0, 0);
          else begin
            pushBurst(len, busM.payload_in);
            expNow = expQ.pop_front();
          end
        end else begin
          expNow = e;
        end
      end
      #1;
      checkOutput("cyc_tx",   32'(busM.tx_out),     32'(expNow.tx));
      checkOutput("cyc_busy", 32'(busM.busy),       32'(expNow.busy));
      checkOutput("cyc_done", 32'(busM.done),       32'(expNow.done));
      checkOutput("cyc_idx",  32'(busM.byte_index), 32'(expNow.idx));
    end
  end

  // Sample log of every instance, one entry per cycle just after the edge.
  initial begin : sampleLog
    forever begin
      @(posedge clk_in);
      #1;
      logM.push_back({busM.tx_out, busM.busy, busM.done});
      logE.push_back({busE.tx_out, busE.busy, busE.done});
      logO.push_back({busO.tx_out, busO.busy, busO.done});
    end
  end

  task automatic applyStimulus(input logic [LW-1:0] len, input logic [NB*8-1:0] pay, input logic rep);
    @(negedge clk_in);
    busM.length     = len;
    busM.payload_in = pay;
    busM.repeat_en  = rep;
    busM.start      = 1'b1;
    logM.delete();
    @(negedge clk_in);
    busM.start = 1'b0;
  endtask

  task automatic decodeMain();
    int         i;
    logic [7:0] v;
    rxBytes.delete();
    i = 0;
    while (i + FR <= logM.size()) begin
      if (logM[i].tx == 1'b0 && logM[i + TPB/2].tx == 1'b0) begin
        for (int j = 0; j < 8; j++) v[j] = logM[i + TPB*(1+j) + TPB/2].tx;
        rxBytes.push_back(v);
        i += FR;
      end else begin
        i++;
      end
    end
  endtask

  task automatic collectDone();
    donePos.delete();
    foreach (logM[i]) if (logM[i].done) donePos.push_back(i);
  endtask

  // Directed scenario sequence.
  initial begin : stimulus
    logic [NB*8-1:0] pay;
    int   bits31 [8];
    logic [7:0] e123 [3];
    bit   seen;
    nChecks = 0;
    nFails  = 0;
    bits31 = '{1, 0, 0, 0, 1, 1, 0, 0};
    e123   = '{8'h31, 8'h32, 8'h33};
    reset = 1'b1;
    busM.start = 1'b0; busM.repeat_en = 1'b0; busM.length = '0; busM.payload_in = '0;
    busE.start = 1'b0; busE.repeat_en = 1'b0; busE.length = '0; busE.payload_in = '0;
    busO.start = 1'b0; busO.repeat_en = 1'b0; busO.length = '0; busO.payload_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    checkOutput("rst_tx",   32'(busM.tx_out), 32'd1);
    checkOutput("rst_busy", 32'(busM.busy), 32'd0);
    checkOutput("rst_done", 32'(busM.done), 32'd0);
    checkOutput("rst_idx",  32'(busM.byte_index), 32'd0);

    $display("[TB] single byte 0x31");
    pay = '0; pay[7:0] = 8'h31;
    applyStimulus(8'd1, pay, 1'b0);
    repeat (45) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t1_start0", 32'(logM[0].tx), 32'd0);
    checkOutput("t1_start3", 32'(logM[3].tx), 32'd0);
    checkOutput("t1_busy0",  32'(logM[0].busy), 32'd1);
    for (int j = 0; j < 8; j++) checkOutput("t1_data", 32'(logM[4 + 4*j + 1].tx), 32'(bits31[j]));
    checkOutput("t1_stop",   32'(logM[36].tx), 32'd1);
    checkOutput("t1_done39", 32'(logM[39].done), 32'd0);
    checkOutput("t1_done40", 32'(logM[40].done), 32'd1);
    checkOutput("t1_busy40", 32'(logM[40].busy), 32'd0);
    checkOutput("t1_done41", 32'(logM[41].done), 32'd0);

    $display("[TB] three bytes 123");
    pay = '0; pay[23:0] = 24'h333231;
    applyStimulus(8'd3, pay, 1'b0);
    repeat (130) @(posedge clk_in);
    @(negedge clk_in);
    decodeMain();
    checkOutput("t2_nbytes", 32'(rxBytes.size()), 32'd3);
    for (int j = 0; j < 3 && j < rxBytes.size(); j++) checkOutput("t2_byte", 32'(rxBytes[j]), 32'(e123[j]));
    collectDone();
    checkOutput("t2_ndone", 32'(donePos.size()), 32'd1);
    if (donePos.size() > 0) checkOutput("t2_donepos", 32'(donePos[0]), 32'd120);

    $display("[TB] parity even/odd, two stop bits, byte 0x07");
    @(negedge clk_in);
    busE.length = 8'd1; busE.payload_in = 32'h07; busE.start = 1'b1;
    busO.length = 8'd1; busO.payload_in = 32'h07; busO.start = 1'b1;
    logE.delete(); logO.delete();
    @(negedge clk_in);
    busE.start = 1'b0; busO.start = 1'b0;
    repeat (55) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t3_e_d7",   32'(logE[33].tx), 32'd0);
    checkOutput("t3_e_par",  32'(logE[37].tx), 32'd1);
    checkOutput("t3_o_par",  32'(logO[37].tx), 32'd0);
    checkOutput("t3_e_stp1", 32'(logE[41].tx), 32'd1);
    checkOutput("t3_e_stp2", 32'(logE[46].tx), 32'd1);
    checkOutput("t3_e_d47",  32'(logE[47].done), 32'd0);
    checkOutput("t3_e_d48",  32'(logE[48].done), 32'd1);
    checkOutput("t3_o_d47",  32'(logO[47].done), 32'd0);
    checkOutput("t3_o_d48",  32'(logO[48].done), 32'd1);
    checkOutput("t3_o_b47",  32'(logO[47].busy), 32'd1);

    $display("[TB] auto-repeat with gap, repeat dropped mid-burst");
    pay = '0; pay[15:0] = 16'h5AA5;
    applyStimulus(8'd2, pay, 1'b1);
    repeat (200) @(posedge clk_in);
    @(negedge clk_in);
    busM.repeat_en = 1'b0;
    repeat (100) @(posedge clk_in);
    @(negedge clk_in);
    collectDone();
    checkOutput("t4_ndone", 32'(donePos.size()), 32'd3);
    if (donePos.size() == 3) begin
      checkOutput("t4_done0", 32'(donePos[0]), 32'd80);
      checkOutput("t4_done1", 32'(donePos[1]), 32'd175);
      checkOutput("t4_done2", 32'(donePos[2]), 32'd270);
    end
    checkOutput("t4_idle", 32'(busM.busy), 32'd0);

    $display("[TB] reset during byte 1");
    pay = '0; pay[23:0] = 24'h434241;
    applyStimulus(8'd3, pay, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk_in);
      if (busM.byte_index == LW'(1)) seen = 1'b1;
    end
    checkOutput("t5_reach_idx1", 32'(seen), 32'd1);
    repeat (10) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    checkOutput("t5_rst_tx",   32'(busM.tx_out), 32'd1);
    checkOutput("t5_rst_busy", 32'(busM.busy), 32'd0);
    reset = 1'b0;
    repeat (130) @(posedge clk_in);
    @(negedge clk_in);
    collectDone();
    checkOutput("t5_nodone", 32'(donePos.size()), 32'd0);
    applyStimulus(8'd1, pay, 1'b0);
    repeat (45) @(posedge clk_in);
    @(negedge clk_in);
    decodeMain();
    checkOutput("t5_nbytes", 32'(rxBytes.size()), 32'd1);
    if (rxBytes.size() > 0) checkOutput("t5_byte0", 32'(rxBytes[0]), 32'h41);

    $display("[TB] zero length");
    applyStimulus(8'd0, pay, 1'b0);
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t6_done0", 32'(logM[0].done), 32'd1);
    checkOutput("t6_busy0", 32'(logM[0].busy), 32'd0);
    checkOutput("t6_tx0",   32'(logM[0].tx), 32'd1);
    checkOutput("t6_done1", 32'(logM[1].done), 32'd0);

    $display("[TB] length 200 clamps to 134, start while busy ignored");
    for (int k = 0; k < NB; k++) pay[8*k +: 8] = 8'(k) ^ 8'h5A;
    applyStimulus(8'd200, pay, 1'b0);
    repeat (100) @(posedge clk_in);
    @(negedge clk_in);
    busM.payload_in = ~pay;
    busM.length = 8'd1;
    busM.start = 1'b1;
    @(negedge clk_in);
    busM.start = 1'b0;
    repeat (NB * FR + 50) @(posedge clk_in);
    @(negedge clk_in);
    decodeMain();
    checkOutput("t6_nframes", 32'(rxBytes.size()), 32'(NB));
    for (int k = 0; k < NB && k < rxBytes.size(); k++)
      checkOutput("t6_byte", 32'(rxBytes[k]), 32'(8'(k) ^ 8'h5A));
    collectDone();
    checkOutput("t6_ndone", 32'(donePos.size()), 32'd1);
    if (donePos.size() > 0) checkOutput("t6_donepos", 32'(donePos[0]), 32'(NB * FR));
    checkOutput("t6_idle", 32'(busM.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
